// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable serial bit-pattern detector with match counter
// Sliding-window compare against a latched pattern of runtime length; one-cycle registered match pulse.
module seq_pattern_detector #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             din,
   input  logic             en,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] pat,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             overlap,
   input  logic             cnt_clr,
   output logic             dout,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [PAT_W-1:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic [PAT_W-1:0] r_cfg_pat;
   logic [LEN_W-1:0] r_cfg_len;
   logic             r_cfg_ovl;
   logic             r_armed;
   logic             r_dout;
   logic [CNT_W-1:0] r_cnt;

   logic [PAT_W-1:0] w_next_hist;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W:0]   w_fill_inc;
   logic [LEN_W-1:0] w_fill_next;
   logic [LEN_W-1:0] w_len_clamp;
   logic             w_hit;

   assign w_next_hist = {r_hist[PAT_W-2:0], din};
   assign w_fill_inc  = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
   assign w_fill_next = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_ONE;
   assign w_len_clamp = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;

   // Only the low cfg_len bits of the window take part in the compare.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (i < int'(r_cfg_len));
      end
   end

   assign w_hit = en && !cfg_load && r_armed
                  && (w_fill_inc >= {1'b0, r_cfg_len})
                  && (((w_next_hist ^ r_cfg_pat) & w_mask) == '0);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_cfg_pat <= '0;
         r_cfg_len <= '0;
         r_cfg_ovl <= 1'b0;
         r_armed   <= 1'b0;
         r_dout    <= 1'b0;
      end else if (cfg_load) begin
         r_cfg_pat <= pat;
         r_cfg_len <= w_len_clamp;
         r_cfg_ovl <= overlap;
         r_armed   <= (pat_len != '0);
         r_hist    <= '0;
         r_fill    <= '0;
         r_dout    <= 1'b0;
      end else if (en) begin
         r_dout <= w_hit;
         if (w_hit && !r_cfg_ovl) begin
            r_hist <= '0;
            r_fill <= '0;
         end else begin
            r_hist <= w_next_hist;
            r_fill <= w_fill_next;
         end
      end else begin
         r_dout <= 1'b0;
      end
   end

   // Clear beats a coincident hit; the count saturates rather than wraps.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (w_hit && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   assign dout      = r_dout;
   assign match_cnt = r_cnt;
   assign armed     = r_armed;

endmodule
